// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: op codes, FSM
// states and datapath width.
package muldiv_sequencer_pkg;

  localparam int XLEN    = 32;
  localparam int LATENCY = 34;

  localparam logic [5:0] OP_MUL    = 6'b001000;
  localparam logic [5:0] OP_MULH   = 6'b001001;
  localparam logic [5:0] OP_MULHSU = 6'b001010;
  localparam logic [5:0] OP_MULHU  = 6'b001011;
  localparam logic [5:0] OP_DIV    = 6'b001100;
  localparam logic [5:0] OP_DIVU   = 6'b001101;
  localparam logic [5:0] OP_REM    = 6'b001110;
  localparam logic [5:0] OP_REMU   = 6'b001111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_FIX,
    S_DONE
  } state_e;

  function automatic logic is_muldiv(input logic [5:0] sel);
    return (sel[5:2] == 4'b0010) || (sel[5:2] == 4'b0011);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_core.sv
// Iterative datapath: 64-bit {hi,lo} shift register plus divisor/multiplicand
// register, advancing one shift-add or restoring shift-subtract per step.
module muldiv_sequencer_core
  import muldiv_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                step,
  input  logic                div_mode,
  input  logic [XLEN-1:0]     load_a,
  input  logic [XLEN-1:0]     load_b,
  output logic [2*XLEN-1:0]   acc
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN:0]     sum;
  logic [XLEN+1:0]   diff;

  // Multiply shifts right with the carry of the partial add; divide shifts
  // left and keeps the trial difference only when it does not borrow.
  always_comb begin
    acc_d = acc_q;
    b_d   = b_q;
    sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    diff  = {1'b0, acc_q[63:31]} - {2'b00, b_q};
    if (load) begin
      acc_d = {32'd0, load_a};
      b_d   = load_b;
    end else if (step) begin
      if (div_mode) begin
        acc_d = diff[33] ? {acc_q[62:0], 1'b0} : {diff[31:0], acc_q[30:0], 1'b1};
      end else begin
        acc_d = {sum, acc_q[31:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      b_q   <= '0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: FSM, operand sign handling, special-case
// resolution and the registered BUSY/DONE/RESULT outputs around the core.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [5:0]      select,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_e            state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_signed, b_signed;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] acc, prod;
  logic [XLEN-1:0]   quot, rem;
  logic              div_zero, div_ovf;

  muldiv_sequencer_core u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (state_q == S_LOAD),
    .step     (state_q == S_ITER),
    .div_mode (op_q[2]),
    .load_a   (a_mag),
    .load_b   (b_mag),
    .acc      (acc)
  );

  // The core works on magnitudes; signs are stripped here and reapplied in FIX.
  always_comb begin
    a_signed = (op_q == OP_MUL) || (op_q == OP_MULH) || (op_q == OP_MULHSU) ||
               (op_q == OP_DIV) || (op_q == OP_REM);
    b_signed = (op_q == OP_MUL) || (op_q == OP_MULH) ||
               (op_q == OP_DIV) || (op_q == OP_REM);
    a_mag    = (a_signed && a_q[31]) ? (~a_q + 32'd1) : a_q;
    b_mag    = (b_signed && b_q[31]) ? (~b_q + 32'd1) : b_q;
    prod     = (a_neg_q ^ b_neg_q) ? (~acc + 64'd1) : acc;
    quot     = (a_neg_q ^ b_neg_q) ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem      = a_neg_q ? (~acc[63:32] + 32'd1) : acc[63:32];
    div_zero = (b_q == 32'd0);
    div_ovf  = a_signed && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && is_muldiv(select)) begin
          op_d    = select;
          a_d     = data1;
          b_d     = data2;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        a_neg_d = a_signed && a_q[31];
        b_neg_d = b_signed && b_q[31];
        cnt_d   = 5'd31;
        busy_d  = 1'b1;
        state_d = S_ITER;
      end
      S_ITER: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = S_FIX;
      end
      S_FIX: begin
        unique case (op_q)
          OP_MUL:                        result_d = prod[31:0];
          OP_MULH, OP_MULHSU, OP_MULHU:  result_d = prod[63:32];
          OP_DIV, OP_DIVU:               result_d = div_zero ? 32'hFFFF_FFFF :
                                                    div_ovf  ? 32'h8000_0000 : quot;
          OP_REM, OP_REMU:               result_d = div_zero ? a_q :
                                                    div_ovf  ? 32'd0 : rem;
          default:                       result_d = 32'd0;
        endcase
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected results are queued as each
// op is issued and popped when DONE pulses.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  select = '0;
  logic [31:0] data1 = '0;
  logic [31:0] data2 = '0;
  logic        busy, done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .select(select),
    .data1(data1), .data2(data2), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [5:0] sel, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic        [63:0] ua, ub, up;
    logic signed [31:0] s1, s2;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    s1 = a;
    s2 = b;
    case (sel)
      OP_MUL:    begin up = ua * ub; return up[31:0]; end
      OP_MULH:   begin sp = sa * sb; return sp[63:32]; end
      OP_MULHSU: begin sp = sa * $signed(ub); return sp[63:32]; end
      OP_MULHU:  begin up = ua * ub; return up[63:32]; end
      OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(s1 / s2);
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:    return (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(s1 % s2);
      OP_REMU:   return (b == 0) ? a : a % b;
      default:   return 32'd0;
    endcase
  endfunction

  // Issues one op from IDLE and waits (bounded) for DONE. Optionally injects a
  // second START with other operands while the first op is running.
  task automatic do_op(input logic [5:0] sel, input logic [31:0] a, input logic [31:0] b,
                       input logic inject, output int lat, output int busy_cycles,
                       output logic busy_after_accept, output logic [31:0] res);
    lat = -1;
    busy_cycles = 0;
    res = 'x;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; select = sel; data1 = a; data2 = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; select = '0; data1 = '0; data2 = '0;
    busy_after_accept = busy;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        res = result;
        break;
      end
      if (busy) busy_cycles++;
      if (inject && i == 5) begin
        start = 1'b1; select = OP_MUL; data1 = 32'd1000; data2 = 32'd1000;
      end
      if (inject && i == 6) begin
        start = 1'b0; select = '0;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_state busy=%b done=%b result=%h required 0/0/0", busy, done, result);
    end
    reset = 1'b0;
  endtask

  task automatic test_mul;
    int lat, bc;
    logic bacc;
    logic [31:0] res, e;
    exp_q.push_back(32'd42);
    do_op(OP_MUL, 32'd7, 32'd6, 1'b0, lat, bc, bacc, res);
    e = exp_q.pop_front();
    checks++;
    if (res !== e) begin errors++; $display("[TB] FAIL mul_7x6 got=%h required=%h", res, e); end
    checks++;
    if (lat !== 34) begin errors++; $display("[TB] FAIL mul_latency got=%0d required=34", lat); end
    checks++;
    if (bc !== 33) begin errors++; $display("[TB] FAIL mul_busy_cycles got=%0d required=33", bc); end
    checks++;
    if (bacc !== 1'b0) begin errors++; $display("[TB] FAIL busy_after_accept got=%b required=0", bacc); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_at_done got=%b required=0", busy); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || result !== 32'd42) begin
      errors++;
      $display("[TB] FAIL result_hold done=%b result=%h required 0/0000002a", done, result);
    end
  endtask

  task automatic test_mulh;
    logic [5:0]  sels[3] = '{OP_MULH, OP_MULHU, OP_MULHSU};
    logic [31:0] as[3]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs[3]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
    logic [31:0] es[3]   = '{32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    int lat, bc;
    logic bacc;
    logic [31:0] res, e;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(es[i]);
      do_op(sels[i], as[i], bs[i], 1'b0, lat, bc, bacc, res);
      e = exp_q.pop_front();
      checks++;
      if (res !== e || lat !== 34) begin
        errors++;
        $display("[TB] FAIL mulh_%0d got=%h lat=%0d required=%h lat=34", i, res, lat, e);
      end
    end
  endtask

  task automatic test_div;
    logic [5:0]  sels[8] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIV, OP_REM};
    logic [31:0] as[8]   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                             32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs[8]   = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] es[8]   = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                             32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int lat, bc;
    logic bacc;
    logic [31:0] res, e;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(es[i]);
      do_op(sels[i], as[i], bs[i], 1'b0, lat, bc, bacc, res);
      e = exp_q.pop_front();
      checks++;
      if (res !== e || lat !== 34) begin
        errors++;
        $display("[TB] FAIL div_%0d got=%h lat=%0d required=%h lat=34", i, res, lat, e);
      end
    end
  endtask

  task automatic test_ignored_start;
    int busy_seen = 0, done_seen = 0;
    int lat, bc;
    logic bacc;
    logic [31:0] res, e;
    @(negedge clk);
    start = 1'b1; select = 6'b000000; data1 = 32'd9; data2 = 32'd9;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy) busy_seen++;
      if (done) done_seen++;
    end
    checks++;
    if (busy_seen !== 0 || done_seen !== 0) begin
      errors++;
      $display("[TB] FAIL illegal_select busy_cycles=%0d done_pulses=%0d required 0/0", busy_seen, done_seen);
    end
    exp_q.push_back(model(OP_DIVU, 32'd1234567, 32'd89));
    do_op(OP_DIVU, 32'd1234567, 32'd89, 1'b1, lat, bc, bacc, res);
    e = exp_q.pop_front();
    checks++;
    if (res !== e || lat !== 34) begin
      errors++;
      $display("[TB] FAIL midop_start got=%h lat=%0d required=%h lat=34", res, lat, e);
    end
  endtask

  task automatic test_reset_midop;
    int done_seen = 0;
    int lat, bc;
    logic bacc;
    logic [31:0] res, e;
    @(negedge clk);
    start = 1'b1; select = OP_MUL; data1 = 32'd123; data2 = 32'd456;
    @(negedge clk);
    start = 1'b0; select = '0;
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_midop busy=%b done=%b result=%h required 0/0/0", busy, done, result);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("[TB] FAIL reset_drops_op done_pulses=%0d required=0", done_seen);
    end
    exp_q.push_back(32'd9);
    do_op(OP_MUL, 32'd3, 32'd3, 1'b0, lat, bc, bacc, res);
    e = exp_q.pop_front();
    checks++;
    if (res !== e || lat !== 34) begin
      errors++;
      $display("[TB] FAIL mul_after_reset got=%h lat=%0d required=%h lat=34", res, lat, e);
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0]  sel;
    logic [31:0] a, b, res, e;
    int lat, bc;
    logic bacc;
    for (int i = 0; i < 8; i++) begin
      sel = OP_MUL | 6'(i);
      a = $urandom;
      b = (i == 5) ? 32'd0 : $urandom;
      exp_q.push_back(model(sel, a, b));
      do_op(sel, a, b, 1'b0, lat, bc, bacc, res);
      e = exp_q.pop_front();
      checks++;
      if (res !== e || lat !== 34) begin
        errors++;
        $display("[TB] FAIL b2b_op%0d a=%h b=%h got=%h lat=%0d required=%h lat=34", i, a, b, res, lat, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_ignored_start();
    test_reset_midop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
